hwag_spi_tx_data_frame: RTL and testbench
=========================================

# hwag_spi_tx_data_frame

Transmit-side framer for the HWAG SPI slave link. It accepts read requests decoded from received `[CMD8]:[ADDR8]:[DATA32]:[CRC8]` frames and fetches the addressed register. It then builds a response frame in the same format, with a CRC8 it computes itself, and feeds that frame byte-by-byte into `spi_slave.bus_in` during the next SPI transaction. Reads are therefore split-transaction: transaction N carries the request, and transaction N+1 returns the response.

## Interface
Parameters:
- `READ_CMD`, default 8'h80: command byte that marks a read request.
- `FRAME_BYTES`, default 7: frame length in bytes (CMD, ADDR, DATA[31:24..7:0], CRC).

Ports:
- `clk`  in  1  system clock; every register in the block is clocked on its rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `spi_ss`  in  1  slave select, active low, already in the `clk` domain.
- `spi_ss_rise`  in  1  one-cycle pulse at the end of a transaction.
- `spi_tx`  in  1  one-cycle pulse when `spi_slave` has loaded `spi_bus_in` into its shifter.
- `spi_hwag_cmd`  in  8  command byte of the last received frame.
- `spi_hwag_addr`  in  8  address byte of the last received frame.
- `spi_crc_rx_equal`  in  1  received-frame CRC matched.
- `rd_data`  in  32  combinational register-file read data for `rd_addr`.
- `rd_addr`  out  8  register-file read address.
- `rd_strobe`  out  1  one-cycle read strobe.
- `spi_bus_in`  out  8  byte offered to `spi_slave` for the next shift.
- `resp_ready`  out  1  a response frame is held and waiting to be sent.
- `frame_sent`  out  1  one-cycle pulse: a valid response has been fully transmitted.

## Operation
- Request acceptance: a request is accepted in the cycle where `spi_ss_rise & spi_crc_rx_equal & (spi_hwag_cmd == READ_CMD)`. Any other frame is ignored by this block.
- Builder state machine, states IDLE, FETCH, CRC, READY:
  - Any state goes to FETCH on an accepted request. An in-progress build or a held response is discarded; the latest request wins.
  - FETCH lasts one cycle. `rd_strobe`=1 and `rd_addr`=latched address. `rd_data` is captured at the end of the cycle into the 48-bit payload {CMD, ADDR, DATA}. Next state: CRC.
  - CRC lasts 48 cycles, processing one payload bit per cycle, MSB first.
    - Algorithm: CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
    - A 6-bit counter runs 0..47. Next state: READY.
  - READY: `resp_ready`=1. Goes to IDLE at the falling edge of `spi_ss` (the response is consumed).
- Transmit path:
  - At the `spi_ss` fall (detected by a registered compare), a 56-bit tx buffer is loaded. It gets {payload, crc} if the state is READY, otherwise all zeros.
  - The byte index is reset to 0. `spi_bus_in` = tx byte 0 from the next cycle.
  - Each `spi_tx` pulse increments the byte index, saturating at 7. `spi_bus_in` = the byte at that index, or 8'h00 for index 7.
  - If the builder is in FETCH or CRC when `spi_ss` falls, the transaction sends all zeros. The build continues, and its result goes to the following transaction.
- `frame_sent` pulses on `spi_ss_rise` when the tx buffer held a valid frame and the index reached 7 (all 7 bytes loaded). A short transaction drops the response silently, with no retry.

## Timing
- Reset (`nrst`=0) forces, immediately and asynchronously:
  - state = IDLE;
  - `rd_addr`=0, `rd_strobe`=0, `spi_bus_in`=0, `resp_ready`=0, `frame_sent`=0;
  - tx buffer, byte index, CRC register and bit counter = 0.
- Reset in mid-build or mid-transmit abandons everything; `spi_bus_in` returns 8'h00.
- Cycle numbering, with cycle 0 = the accepted request:
  - cycle 1: FETCH, `rd_strobe`=1;
  - cycles 2..49: CRC;
  - cycle 50 onward: `resp_ready`=1.
- Build latency is 50 cycles.
- `spi_bus_in` updates in the cycle after `spi_ss` falls or after an `spi_tx` pulse. It is stable until the next `spi_tx` pulse.
- Simultaneous `spi_ss_rise` and `spi_tx`: the index increments first, then the `frame_sent` check uses the incremented index.
- An accepted request can coincide with `spi_ss_rise` of a transaction that carried a READY response. In that case `frame_sent` still pulses, and the builder restarts FETCH.
- All outputs are registered.

## Test plan
- Basic read:
  - Stimulus: request CMD=0x80, ADDR=0x01, with `rd_data`=0x00000000 at FETCH.
  - Required: `rd_strobe` in cycle 1 with `rd_addr`=0x01; `resp_ready` rises in cycle 50.
  - Required: the next transaction shifts 80 01 00 00 00 00 8E, and `frame_sent` pulses.
- Data ordering:
  - Stimulus: `rd_data`=0x12345678.
  - Required: bytes 2..5 are 12 34 56 78; the CRC matches a CRC-8/0x07 reference model.
- Filtered requests:
  - Stimulus: `spi_crc_rx_equal`=0, or CMD=0x01.
  - Required: no `rd_strobe`; the next transaction sends seven 0x00 bytes, and `frame_sent` stays low.
- Early select:
  - Stimulus: `spi_ss` falls 10 cycles after an accepted request.
  - Required: that transaction sends zeros; the following transaction sends the valid frame.
- Overflow and short transactions:
  - Stimulus: 9 `spi_tx` pulses in one transaction.
  - Required: bytes 7 and beyond are 0x00.
  - Stimulus: a transaction with only 4 pulses.
  - Required: `frame_sent`=0, and the response is not re-sent.
- Reset:
  - Stimulus: `nrst` pulsed low during CRC cycle 20, and again during transmit byte 3.
  - Required: all outputs 0 immediately; state IDLE; the next transaction sends zeros.

Source files
------------

// File: rtl/hwag_spi_tx_data_frame.sv
// Transmit-side framer for the HWAG SPI slave: fetches the register named by a read
// request, appends a CRC-8/0x07 and streams the 7-byte response during the next transaction.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no response pending
// FETCH | one cycle: rd_strobe high, rd_data captured into the payload
// CRC   | 48 cycles: one payload bit per cycle into the CRC, MSB first
// READY | response held; consumed at the next spi_ss fall
module hwag_spi_tx_data_frame #(
    parameter logic [7:0] READ_CMD    = 8'h80,
    parameter int         FRAME_BYTES = 7
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        spi_ss,
    input  logic        spi_ss_rise,
    input  logic        spi_tx,
    input  logic [7:0]  spi_hwag_cmd,
    input  logic [7:0]  spi_hwag_addr,
    input  logic        spi_crc_rx_equal,
    input  logic [31:0] rd_data,
    output logic [7:0]  rd_addr,
    output logic        rd_strobe,
    output logic [7:0]  spi_bus_in,
    output logic        resp_ready,
    output logic        frame_sent
);

    typedef enum logic [1:0] {IDLE, FETCH, CRC, READY} state_t;

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);
    localparam logic [5:0] LAST_BIT = 6'd47;

    state_t      state_q, state_d;
    logic        ss_q, ss_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [47:0] payload_q, payload_d;
    logic [7:0]  crc_q, crc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [55:0] tx_buf_q, tx_buf_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  spi_bus_in_q, spi_bus_in_d;
    logic        resp_ready_q, resp_ready_d;
    logic        frame_sent_q, frame_sent_d;

    logic accept;
    logic ss_fall;
    logic crc_fb;

    function automatic logic [7:0] tx_byte(input logic [55:0] frame, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = frame[55:48];
            3'd1:    b = frame[47:40];
            3'd2:    b = frame[39:32];
            3'd3:    b = frame[31:24];
            3'd4:    b = frame[23:16];
            3'd5:    b = frame[15:8];
            3'd6:    b = frame[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d      = state_q;
        ss_d         = spi_ss;
        rd_addr_d    = rd_addr_q;
        rd_strobe_d  = 1'b0;
        payload_d    = payload_q;
        crc_d        = crc_q;
        bit_cnt_d    = bit_cnt_q;
        tx_buf_d     = tx_buf_q;
        idx_d        = idx_q;
        tx_valid_d   = tx_valid_q;
        spi_bus_in_d = spi_bus_in_q;
        frame_sent_d = 1'b0;

        accept  = spi_ss_rise & spi_crc_rx_equal & (spi_hwag_cmd == READ_CMD);
        ss_fall = ss_q & ~spi_ss;
        crc_fb  = crc_q[7] ^ payload_q[LAST_BIT - bit_cnt_q];

        case (state_q)
            FETCH: begin
                payload_d = {READ_CMD, rd_addr_q, rd_data};
                crc_d     = 8'h00;
                bit_cnt_d = 6'd0;
                state_d   = CRC;
            end
            CRC: begin
                crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = 6'd0;
                    state_d   = READY;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            READY: begin
                if (ss_fall) state_d = IDLE;
            end
            default: ;
        endcase

        // The latest request wins, discarding any build or held response.
        if (accept) begin
            state_d     = FETCH;
            rd_addr_d   = spi_hwag_addr;
            rd_strobe_d = 1'b1;
            crc_d       = 8'h00;
            bit_cnt_d   = 6'd0;
        end
        resp_ready_d = (state_d == READY);

        if (ss_fall) begin
            idx_d = 3'd0;
            if (state_q == READY) begin
                tx_buf_d   = {payload_q, crc_q};
                tx_valid_d = 1'b1;
            end else begin
                tx_buf_d   = '0;
                tx_valid_d = 1'b0;
            end
            spi_bus_in_d = tx_byte(tx_buf_d, idx_d);
        end else if (spi_tx) begin
            if (idx_q != LAST_IDX) idx_d = idx_q + 3'd1;
            spi_bus_in_d = tx_byte(tx_buf_q, idx_d);
        end

        // Checked against the already-incremented index so a final spi_tx on the rise counts.
        if (spi_ss_rise) begin
            frame_sent_d = tx_valid_q & (idx_d == LAST_IDX);
            tx_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            ss_q         <= 1'b1;
            rd_addr_q    <= 8'h00;
            rd_strobe_q  <= 1'b0;
            payload_q    <= '0;
            crc_q        <= 8'h00;
            bit_cnt_q    <= 6'd0;
            tx_buf_q     <= '0;
            idx_q        <= 3'd0;
            tx_valid_q   <= 1'b0;
            spi_bus_in_q <= 8'h00;
            resp_ready_q <= 1'b0;
            frame_sent_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ss_q         <= ss_d;
            rd_addr_q    <= rd_addr_d;
            rd_strobe_q  <= rd_strobe_d;
            payload_q    <= payload_d;
            crc_q        <= crc_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_buf_q     <= tx_buf_d;
            idx_q        <= idx_d;
            tx_valid_q   <= tx_valid_d;
            spi_bus_in_q <= spi_bus_in_d;
            resp_ready_q <= resp_ready_d;
            frame_sent_q <= frame_sent_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign rd_strobe  = rd_strobe_q;
    assign spi_bus_in = spi_bus_in_q;
    assign resp_ready = resp_ready_q;
    assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
// Directed bench for hwag_spi_tx_data_frame: a vector table of read requests plus
// hand-written sequences for early select, overflow, short transfers and resets.
module tb_hwag_spi_tx_data_frame;

    logic        clk = 1'b0;
    logic        nrst;
    logic        spi_ss;
    logic        spi_ss_rise;
    logic        spi_tx;
    logic [7:0]  spi_hwag_cmd;
    logic [7:0]  spi_hwag_addr;
    logic        spi_crc_rx_equal;
    logic [31:0] rd_data;
    logic [7:0]  rd_addr;
    logic        rd_strobe;
    logic [7:0]  spi_bus_in;
    logic        resp_ready;
    logic        frame_sent;

    always #5 clk = ~clk;

    hwag_spi_tx_data_frame dut (
        .clk              (clk),
        .nrst             (nrst),
        .spi_ss           (spi_ss),
        .spi_ss_rise      (spi_ss_rise),
        .spi_tx           (spi_tx),
        .spi_hwag_cmd     (spi_hwag_cmd),
        .spi_hwag_addr    (spi_hwag_addr),
        .spi_crc_rx_equal (spi_crc_rx_equal),
        .rd_data          (rd_data),
        .rd_addr          (rd_addr),
        .rd_strobe        (rd_strobe),
        .spi_bus_in       (spi_bus_in),
        .resp_ready       (resp_ready),
        .frame_sent       (frame_sent)
    );

    // Register-file model: only the expected address returns the expected data.
    logic [7:0]  cur_addr;
    logic [31:0] cur_data;
    assign rd_data = (rd_addr == cur_addr) ? cur_data : 32'hBAD0_BAD0;

    int strobe_cnt = 0;
    always @(negedge clk) if (rd_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] crc8_ref(input logic [47:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 5; b >= 0; b--) begin
            c = c ^ p[b*8 +: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [55:0] mk_frame(input logic [7:0] a, input logic [31:0] d);
        logic [47:0] p;
        p = {8'h80, a, d};
        return {p, crc8_ref(p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rx_bytes [10];
    logic       fs_seen;

    function automatic logic [55:0] rx_frame();
        return {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3],
                rx_bytes[4], rx_bytes[5], rx_bytes[6]};
    endfunction

    // One transaction: select low, n spi_tx pulses (byte sampled before each), then the
    // rise carrying rcmd/raddr. Returns one cycle after the rise.
    task automatic xfer(input int n, input bit tx_on_rise, input logic [7:0] rcmd,
                        input logic [7:0] raddr);
        bit risen;
        risen = 1'b0;
        for (int i = 0; i < 10; i++) rx_bytes[i] = 8'hEE;
        spi_ss = 1'b0;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            rx_bytes[i] = spi_bus_in;
            spi_tx = 1'b1;
            if (tx_on_rise && i == n - 1) begin
                spi_ss = 1'b1; spi_ss_rise = 1'b1;
                spi_hwag_cmd = rcmd; spi_hwag_addr = raddr;
                risen = 1'b1;
                tick();
            end else begin
                tick();
                spi_tx = 1'b0;
                tick();
            end
        end
        if (!risen) begin
            spi_ss = 1'b1; spi_ss_rise = 1'b1;
            spi_hwag_cmd = rcmd; spi_hwag_addr = raddr;
            tick();
        end
        spi_tx = 1'b0;
        spi_ss_rise = 1'b0;
        spi_hwag_cmd = 8'h00;
        fs_seen = frame_sent;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100 && resp_ready !== 1'b1; i++) tick();
        check(name, resp_ready, 1'b1);
    endtask

    function automatic logic [63:0] outs();
        return {rd_addr, rd_strobe, spi_bus_in, resp_ready, frame_sent};
    endfunction

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic        crc_ok;
        logic [31:0] data;
        logic        exp_acc;
        logic [55:0] exp_frame;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int s0;
        vecs[0] = '{8'h80, 8'h01, 1'b1, 32'h0000_0000, 1'b1, 56'h80_01_00000000_8E};
        vecs[1] = '{8'h80, 8'hA5, 1'b1, 32'h1234_5678, 1'b1, mk_frame(8'hA5, 32'h1234_5678)};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 32'hDEAD_BEEF, 1'b0, 56'h0};
        vecs[3] = '{8'h01, 8'h01, 1'b1, 32'hDEAD_BEEF, 1'b0, 56'h0};
        vecs[4] = '{8'h80, 8'hFF, 1'b1, 32'hFFFF_FFFF, 1'b1, mk_frame(8'hFF, 32'hFFFF_FFFF)};

        nrst = 1'b0; spi_ss = 1'b1; spi_ss_rise = 1'b0; spi_tx = 1'b0;
        spi_hwag_cmd = 8'h00; spi_hwag_addr = 8'h00; spi_crc_rx_equal = 1'b1;
        cur_addr = 8'h00; cur_data = 32'h0;
        #2;
        check("reset_outputs", outs(), 64'h0);
        tick(); tick();
        nrst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            cur_addr = vecs[v].addr;
            cur_data = vecs[v].data;
            spi_crc_rx_equal = vecs[v].crc_ok;
            s0 = strobe_cnt;
            xfer(0, 1'b0, vecs[v].cmd, vecs[v].addr);
            spi_crc_rx_equal = 1'b1;
            check($sformatf("v%0d_strobe_c1", v), rd_strobe, vecs[v].exp_acc);
            if (vecs[v].exp_acc) check($sformatf("v%0d_rd_addr", v), rd_addr, vecs[v].addr);
            repeat (48) tick();
            check($sformatf("v%0d_ready_c49", v), resp_ready, 1'b0);
            tick();
            check($sformatf("v%0d_ready_c50", v), resp_ready, vecs[v].exp_acc);
            check($sformatf("v%0d_strobe_count", v), 64'(strobe_cnt - s0), 64'(vecs[v].exp_acc));
            xfer(7, 1'b0, 8'h00, 8'h00);
            check($sformatf("v%0d_frame", v), rx_frame(), vecs[v].exp_frame);
            check($sformatf("v%0d_frame_sent", v), fs_seen, vecs[v].exp_acc);
            check($sformatf("v%0d_ready_after", v), resp_ready, 1'b0);
            tick();
            check($sformatf("v%0d_fs_one_cycle", v), frame_sent, 1'b0);
        end

        // Early select: transaction starts while CRC is still running.
        cur_addr = 8'h33; cur_data = 32'hCAFE_F00D;
        xfer(0, 1'b0, 8'h80, 8'h33);
        repeat (9) tick();
        xfer(7, 1'b0, 8'h00, 8'h00);
        check("early_frame_zero", rx_frame(), 56'h0);
        check("early_fs", fs_seen, 1'b0);
        wait_ready("early_ready");
        xfer(7, 1'b0, 8'h00, 8'h00);
        check("early_next_frame", rx_frame(), mk_frame(8'h33, 32'hCAFE_F00D));
        check("early_next_fs", fs_seen, 1'b1);

        // Overflow: 9 pulses, bytes past the frame read as zero.
        cur_addr = 8'h44; cur_data = 32'h0102_0304;
        xfer(0, 1'b0, 8'h80, 8'h44);
        wait_ready("ovf_ready");
        xfer(9, 1'b0, 8'h00, 8'h00);
        check("ovf_frame", rx_frame(), mk_frame(8'h44, 32'h0102_0304));
        check("ovf_byte7", rx_bytes[7], 8'h00);
        check("ovf_byte8", rx_bytes[8], 8'h00);
        check("ovf_fs", fs_seen, 1'b1);

        // Short transaction drops the response with no retry.
        cur_addr = 8'h55; cur_data = 32'h89AB_CDEF;
        xfer(0, 1'b0, 8'h80, 8'h55);
        wait_ready("short_ready");
        xfer(4, 1'b0, 8'h00, 8'h00);
        check("short_bytes", {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]}, 32'h8055_89AB);
        check("short_fs", fs_seen, 1'b0);
        xfer(7, 1'b0, 8'h00, 8'h00);
        check("short_no_retry", rx_frame(), 56'h0);
        check("short_no_retry_fs", fs_seen, 1'b0);

        // Last spi_tx coincident with spi_ss_rise still completes the frame.
        cur_addr = 8'h66; cur_data = 32'h0F0F_F0F0;
        xfer(0, 1'b0, 8'h80, 8'h66);
        wait_ready("coinc_tx_ready");
        xfer(7, 1'b1, 8'h00, 8'h00);
        check("coinc_tx_frame", rx_frame(), mk_frame(8'h66, 32'h0F0F_F0F0));
        check("coinc_tx_fs", fs_seen, 1'b1);

        // A new request on the rise of the transaction carrying a READY response.
        cur_addr = 8'h10; cur_data = 32'hA1B2_C3D4;
        xfer(0, 1'b0, 8'h80, 8'h10);
        wait_ready("coinc_req_ready");
        cur_addr = 8'h20; cur_data = 32'h55AA_00FF;
        xfer(7, 1'b0, 8'h80, 8'h20);
        check("coinc_req_frame_a", rx_frame(), mk_frame(8'h10, 32'hA1B2_C3D4));
        check("coinc_req_fs", fs_seen, 1'b1);
        check("coinc_req_strobe", rd_strobe, 1'b1);
        check("coinc_req_addr", rd_addr, 8'h20);
        wait_ready("coinc_req_ready_b");
        xfer(7, 1'b0, 8'h00, 8'h00);
        check("coinc_req_frame_b", rx_frame(), mk_frame(8'h20, 32'h55AA_00FF));

        // Reset during CRC cycle 20.
        cur_addr = 8'h77; cur_data = 32'h7777_7777;
        xfer(0, 1'b0, 8'h80, 8'h77);
        repeat (19) tick();
        nrst = 1'b0;
        #1;
        check("rst_crc_outputs", outs(), 64'h0);
        tick();
        nrst = 1'b1;
        repeat (60) tick();
        check("rst_crc_idle", resp_ready, 1'b0);
        xfer(7, 1'b0, 8'h00, 8'h00);
        check("rst_crc_frame", rx_frame(), 56'h0);
        check("rst_crc_fs", fs_seen, 1'b0);

        // Reset while byte 3 is on the bus.
        cur_addr = 8'h5A; cur_data = 32'h1122_3344;
        xfer(0, 1'b0, 8'h80, 8'h5A);
        wait_ready("rst_tx_ready");
        spi_ss = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            spi_tx = 1'b1; tick();
            spi_tx = 1'b0; tick();
        end
        check("rst_tx_byte3", spi_bus_in, 8'h22);
        nrst = 1'b0;
        #1;
        check("rst_tx_outputs", outs(), 64'h0);
        tick();
        nrst = 1'b1;
        tick();
        spi_ss = 1'b1; spi_ss_rise = 1'b1;
        tick();
        spi_ss_rise = 1'b0;
        check("rst_tx_fs", frame_sent, 1'b0);
        xfer(7, 1'b0, 8'h00, 8'h00);
        check("rst_tx_frame", rx_frame(), 56'h0);
        check("rst_tx_ready_after", resp_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
